// File: rtl/dmem_io_responder.sv
// M-stage data-bus responder: word RAM plus LED, switch and cycle-counter I/O behind a
// Req/Ready/RValid handshake stretched by WAIT wait states.
module dmem_io_responder #(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 1
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Req,
   input  logic        We,
   input  logic [31:0] Addr,
   input  logic [31:0] WData,
   output logic        Ready,
   output logic [31:0] RData,
   output logic        RValid,
   output logic        Err,
   input  logic [7:0]  Switch,
   output logic [7:0]  Led
);
   localparam int          RAM_DEPTH     = 1 << ADDR_W;
   localparam logic [2:0]  WAIT_CNT      = 3'(WAIT);
   localparam logic [29:0] LED_WORD      = 30'h2000_0000;
   localparam logic [29:0] SW_WORD       = 30'h2000_0001;
   localparam logic [29:0] CNT_WORD      = 30'h2000_0002;
   localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {IDLE, WAITS, ACC} state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [2:0]  wait_reg;
   logic [2:0]  wait_next;
   logic        accept;

   logic        we_reg;
   logic [29:0] word_reg;
   logic [31:0] wdata_reg;

   logic [7:0]  led_reg;
   logic [7:0]  sync1_reg;
   logic [7:0]  sync2_reg;
   logic [31:0] cycle_reg;
   logic [31:0] rdata_reg;
   logic        rvalid_reg;
   logic        err_reg;

   logic        in_acc;
   logic        is_ram;
   logic        is_led;
   logic        is_sw;
   logic        is_cnt;
   logic        is_unmapped;
   logic        ram_we;
   logic        led_we;
   logic        cnt_clr;
   logic [31:0] load_data;

   logic [31:0]       ram [0:RAM_DEPTH-1];
   logic [ADDR_W-1:0] ram_raddr;
   logic [31:0]       ram_q;

   // Byte-lane bits carry no information on this word-only bus.
   logic unused_addr_bits;
   assign unused_addr_bits = ^Addr[1:0];

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg <= IDLE;
         wait_reg  <= 3'd0;
      end else begin
         state_reg <= state_next;
         wait_reg  <= wait_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      wait_next  = wait_reg;
      accept     = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (Req) begin
               accept     = 1'b1;
               wait_next  = WAIT_CNT;
               state_next = (WAIT_CNT == 3'd0) ? ACC : WAITS;
            end
         end
         WAITS: begin
            wait_next = wait_reg - 3'd1;
            if (wait_reg == 3'd1) begin
               state_next = ACC;
            end
         end
         ACC: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         we_reg    <= 1'b0;
         word_reg  <= 30'd0;
         wdata_reg <= 32'd0;
      end else if (accept) begin
         we_reg    <= We;
         word_reg  <= Addr[31:2];
         wdata_reg <= WData;
      end
   end

   assign in_acc      = (state_reg == ACC);
   assign is_ram      = ~word_reg[29];
   assign is_led      = (word_reg == LED_WORD);
   assign is_sw       = (word_reg == SW_WORD);
   assign is_cnt      = (word_reg == CNT_WORD);
   assign is_unmapped = word_reg[29] & ~(is_led | is_sw | is_cnt);
   assign ram_we      = in_acc & we_reg & is_ram;
   assign led_we      = in_acc & we_reg & is_led;
   assign cnt_clr     = in_acc & we_reg & is_cnt;

   // Read the incoming address on the accept edge so ram_q is already valid in ACC even with WAIT=0.
   assign ram_raddr = (state_reg == IDLE) ? Addr[ADDR_W+1:2] : word_reg[ADDR_W-1:0];

   always_ff @(posedge Clk) begin
      if (ram_we) begin
         ram[word_reg[ADDR_W-1:0]] <= wdata_reg;
      end
      ram_q <= ram[ram_raddr];
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync1_reg <= 8'd0;
         sync2_reg <= 8'd0;
      end else begin
         sync1_reg <= Switch;
         sync2_reg <= sync1_reg;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cycle_reg <= 32'd0;
      end else begin
         cycle_reg <= cnt_clr ? 32'd0 : cycle_reg + 32'd1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         led_reg <= 8'd0;
      end else if (led_we) begin
         led_reg <= wdata_reg[7:0];
      end
   end

   always_comb begin
      load_data = UNMAPPED_DATA;
      if (is_ram) begin
         load_data = ram_q;
      end else if (is_led) begin
         load_data = {24'd0, led_reg};
      end else if (is_sw) begin
         load_data = {24'd0, sync2_reg};
      end else if (is_cnt) begin
         load_data = cycle_reg;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rdata_reg  <= 32'd0;
         rvalid_reg <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         rvalid_reg <= in_acc & ~we_reg;
         err_reg    <= in_acc & is_unmapped;
         if (in_acc & ~we_reg) begin
            rdata_reg <= load_data;
         end
      end
   end

   assign Ready  = (state_reg == IDLE);
   assign RData  = rdata_reg;
   assign RValid = rvalid_reg;
   assign Err    = err_reg;
   assign Led    = led_reg;

endmodule

// File: tb/tb_dmem_io_responder.sv
// Three responders (WAIT = 1, 0, 3) driven by directed and random traffic and compared every
// cycle against a transaction-level model of the bus, RAM and I/O registers.
module tb_dmem_io_responder;
   localparam int ADDR_W = 10;
   localparam int NI     = 3;

   logic        clk;
   logic        rst_n;
   logic        req   [NI];
   logic        we    [NI];
   logic [31:0] addr  [NI];
   logic [31:0] wdata [NI];
   logic        ready [NI];
   logic [31:0] rdata [NI];
   logic        rvalid[NI];
   logic        err   [NI];
   logic [7:0]  led   [NI];
   logic [7:0]  sw;

   int n_vec;
   int n_bad;

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         localparam int WI = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;
         dmem_io_responder #(.ADDR_W(ADDR_W), .WAIT(WI)) u_dut (
            .Clk   (clk),
            .Rst_n (rst_n),
            .Req   (req[gi]),
            .We    (we[gi]),
            .Addr  (addr[gi]),
            .WData (wdata[gi]),
            .Ready (ready[gi]),
            .RData (rdata[gi]),
            .RValid(rvalid[gi]),
            .Err   (err[gi]),
            .Switch(sw),
            .Led   (led[gi])
         );
      end
   endgenerate

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model (transaction level) ----------------
   int unsigned edge_n;
   bit          pend_m [NI];
   bit          acc_m  [NI];
   int unsigned done_m [NI];
   bit          t_we   [NI];
   logic [31:0] t_addr [NI];
   logic [31:0] t_wd   [NI];
   logic [7:0]  led_m  [NI];
   logic [31:0] cnt_m  [NI];
   bit          rv_m   [NI];
   bit          er_m   [NI];
   logic [31:0] rd_m   [NI];
   logic [31:0] ram_m  [int];
   logic [7:0]  swq    [$];

   function automatic int wait_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 0 : 3;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         pend_m[k] = 1'b0;
         acc_m[k]  = 1'b0;
         led_m[k]  = 8'h00;
         cnt_m[k]  = 32'd0;
         rv_m[k]   = 1'b0;
         er_m[k]   = 1'b0;
         rd_m[k]   = 32'd0;
      end
      swq.delete();
   endtask

   task automatic model_edge();
      logic [7:0]  sync_v;
      logic [31:0] cnt_pre;
      logic [31:0] wa;
      logic [31:0] rd;
      bit          clr;
      int          key;
      if (!rst_n) begin
         model_reset();
         return;
      end
      // switches seen by a read at this edge are those sampled two edges earlier
      sync_v = (swq.size() >= 2) ? swq[swq.size() - 2] : 8'h00;
      swq.push_back(sw);
      if (swq.size() > 4) void'(swq.pop_front());
      for (int k = 0; k < NI; k++) begin
         cnt_pre = cnt_m[k];
         clr     = 1'b0;
         rv_m[k] = 1'b0;
         er_m[k] = 1'b0;
         acc_m[k] = 1'b0;
         if (!pend_m[k]) begin
            if (req[k]) begin
               pend_m[k] = 1'b1;
               acc_m[k]  = 1'b1;
               done_m[k] = edge_n + wait_of(k) + 1;
               t_we[k]   = we[k];
               t_addr[k] = addr[k];
               t_wd[k]   = wdata[k];
            end
         end else if (edge_n == done_m[k]) begin
            pend_m[k] = 1'b0;
            wa = {t_addr[k][31:2], 2'b00};
            rd = 32'hDEAD_BEEF;
            if (!wa[31]) begin
               key = k * (1 << ADDR_W) + int'(t_addr[k][ADDR_W+1:2]);
               if (t_we[k]) ram_m[key] = t_wd[k];
               else rd = ram_m[key];
            end else if (wa == 32'h8000_0000) begin
               if (t_we[k]) led_m[k] = t_wd[k][7:0];
               else rd = {24'd0, led_m[k]};
            end else if (wa == 32'h8000_0004) begin
               rd = {24'd0, sync_v};
            end else if (wa == 32'h8000_0008) begin
               if (t_we[k]) clr = 1'b1;
               else rd = cnt_pre;
            end else begin
               er_m[k] = 1'b1;
            end
            if (!t_we[k]) begin
               rv_m[k] = 1'b1;
               rd_m[k] = rd;
            end
         end
         cnt_m[k] = clr ? 32'd0 : cnt_pre + 32'd1;
      end
      edge_n++;
   endtask

   // ---------------- checking ----------------
   task automatic chk32(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input int k, input logic act, input logic exp);
      chk32(nm, k, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic check_all();
      for (int k = 0; k < NI; k++) begin
         chk1("ready", k, ready[k], !pend_m[k]);
         chk1("rvalid", k, rvalid[k], rv_m[k]);
         chk1("err", k, err[k], er_m[k]);
         chk32("led", k, {24'd0, led[k]}, {24'd0, led_m[k]});
         if (rv_m[k]) chk32("rdata", k, rdata[k], rd_m[k]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   // ---------------- stimulus ----------------
   task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (acc_m[k]) break;
      end
      req[k] = 1'b0;
      $display("inst%0d W=%0d %s addr=%h wdata=%h t=%0t", k, wait_of(k), w ? "ST" : "LD", a, d, $time);
   endtask

   task automatic access(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] got, output logic gerr, output logic grv, output int lows);
      issue(k, w, a, d);
      lows = ready[k] ? 0 : 1;
      for (int i = 0; i < 16; i++) begin
         if (!pend_m[k]) break;
         tick();
         if (!ready[k]) lows++;
      end
      got  = rdata[k];
      gerr = err[k];
      grv  = rvalid[k];
   endtask

   function automatic int pool_word(input int j);
      return (j * 37 + 5) % (1 << ADDR_W);
   endfunction

   initial begin
      logic [31:0] got;
      logic        ge;
      logic        gr;
      int          lows;
      int          nrv;
      int          op;
      bit          w;
      logic [31:0] a;
      logic [31:0] d;

      n_vec = 0; n_bad = 0; edge_n = 0;
      rst_n = 1'b0; sw = 8'h00;
      for (int k = 0; k < NI; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0;
      end
      model_reset();
      repeat (3) tick();
      for (int k = 0; k < NI; k++) begin
         chk1("reset ready", k, ready[k], 1'b1);
         chk1("reset rvalid", k, rvalid[k], 1'b0);
         chk1("reset err", k, err[k], 1'b0);
         chk32("reset rdata", k, rdata[k], 32'd0);
         chk32("reset led", k, {24'd0, led[k]}, 32'd0);
      end
      rst_n = 1'b1;
      tick();

      // WAIT=1: RAM store/load and aliasing
      access(0, 1'b1, 32'h0000_0010, 32'h1234_5678, got, ge, gr, lows);
      chk32("store ready-low cycles", 0, 32'(lows), 32'd2);
      access(0, 1'b0, 32'h0000_0010, 32'd0, got, ge, gr, lows);
      chk32("ram load", 0, got, 32'h1234_5678);
      chk32("model ram load", 0, rd_m[0], 32'h1234_5678);
      chk1("ram load rvalid", 0, gr, 1'b1);
      chk32("load ready-low cycles", 0, 32'(lows), 32'd2);
      access(0, 1'b0, 32'h0000_1010, 32'd0, got, ge, gr, lows);
      chk32("alias load", 0, got, 32'h1234_5678);

      // LED register
      access(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFA5, got, ge, gr, lows);
      chk32("led after store", 0, {24'd0, led[0]}, 32'h0000_00A5);
      chk1("store no rvalid", 0, gr, 1'b0);
      access(0, 1'b0, 32'h8000_0000, 32'd0, got, ge, gr, lows);
      chk32("led load", 0, got, 32'h0000_00A5);

      // switches
      sw = 8'h3C;
      repeat (2) tick();
      access(0, 1'b0, 32'h8000_0004, 32'd0, got, ge, gr, lows);
      chk32("switch load", 0, got, 32'h0000_003C);
      chk32("model switch load", 0, rd_m[0], 32'h0000_003C);
      access(0, 1'b1, 32'h8000_0004, 32'h0000_0011, got, ge, gr, lows);
      chk1("switch store err", 0, ge, 1'b0);
      chk32("switch store led", 0, {24'd0, led[0]}, 32'h0000_00A5);

      // unmapped I/O
      access(0, 1'b0, 32'h8000_0010, 32'd0, got, ge, gr, lows);
      chk32("unmapped load", 0, got, 32'hDEAD_BEEF);
      chk1("unmapped load err", 0, ge, 1'b1);
      chk1("unmapped load rvalid", 0, gr, 1'b1);
      access(0, 1'b1, 32'h8000_0010, 32'h0000_00FF, got, ge, gr, lows);
      chk1("unmapped store err", 0, ge, 1'b1);
      chk1("unmapped store rvalid", 0, gr, 1'b0);
      chk32("unmapped store led", 0, {24'd0, led[0]}, 32'h0000_00A5);

      // WAIT=0: counter clear then back-to-back read
      access(1, 1'b1, 32'h8000_0008, 32'hFFFF_FFFF, got, ge, gr, lows);
      chk32("w0 ready-low cycles", 1, 32'(lows), 32'd1);
      access(1, 1'b0, 32'h8000_0008, 32'd0, got, ge, gr, lows);
      chk32("counter after clear", 1, got, 32'h0000_0001);
      chk32("model counter after clear", 1, rd_m[1], 32'h0000_0001);
      access(1, 1'b1, 32'h0000_0040, 32'h0000_55AA, got, ge, gr, lows);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0000_0040;
      nrv = 0;
      repeat (8) begin
         tick();
         if (rvalid[1]) nrv++;
      end
      req[1] = 1'b0;
      chk32("held-req rvalid pulses", 1, 32'(nrv), 32'd4);

      // WAIT=3: reset during wait states aborts the store
      access(2, 1'b1, 32'h0000_0020, 32'h0000_0000, got, ge, gr, lows);
      chk32("w3 ready-low cycles", 2, 32'(lows), 32'd4);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h0000_0020; wdata[2] = 32'hCAFE_F00D;
      tick();
      req[2] = 1'b0;
      tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk1("mid-reset ready", 2, ready[2], 1'b1);
      chk1("mid-reset rvalid", 2, rvalid[2], 1'b0);
      chk32("mid-reset led", 0, {24'd0, led[0]}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      access(2, 1'b0, 32'h0000_0020, 32'd0, got, ge, gr, lows);
      chk32("aborted store", 2, got, 32'h0000_0000);

      // random traffic
      for (int k = 0; k < NI; k++) begin
         for (int j = 0; j < 8; j++) begin
            access(k, 1'b1, 32'(pool_word(j)) << 2, $urandom(), got, ge, gr, lows);
         end
         for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 9);
            w  = 1'($urandom_range(0, 1));
            d  = $urandom();
            case (op)
               4:       a = 32'h8000_0000 | 32'($urandom_range(0, 3));
               5:       a = 32'h8000_0004 | 32'($urandom_range(0, 3));
               6:       a = 32'h8000_0008 | 32'($urandom_range(0, 3));
               7:       a = 32'h8000_0000 | (32'($urandom_range(3, 100000)) << 2) | 32'($urandom_range(0, 3));
               default: a = ($urandom() & 32'h7FFF_F003) | (32'(pool_word($urandom_range(0, 7))) << 2);
            endcase
            if (op >= 8) w = 1'b0;
            issue(k, w, a, d);
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom());
            repeat ($urandom_range(0, 2)) tick();
         end
         repeat (6) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
